// File: rtl/pipeline_exec_ctrl.sv
// Run controller for the 5-stage pipeline: continuous run, single step, HALT
// detection at IF, post-HALT drain, and an executed-cycle counter for debug.
//
//  state | meaning
//  IDLE  | pipeline frozen, waiting for start/step
//  RUN   | free-running; advances whenever not externally stalled
//  STEP  | one advance cycle, then back to IDLE (or DONE when drain ends)
//  DRAIN | HALT seen at IF; bubbles injected until in-flight work retires
//  DONE  | program finished; frozen until clear
module pipeline_exec_ctrl #(
  parameter int              SIZE         = 32,
  parameter logic [SIZE-1:0] HALT_WORD    = {SIZE{1'b1}},
  parameter int              DRAIN_CYCLES = 4,
  parameter int              CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_prog_loaded,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_halt_req,
  input  logic             i_clear,
  input  logic             i_ext_stall,
  input  logic [SIZE-1:0]  i_if_instruction,
  output logic             o_stall,
  output logic             o_pc_hold,
  output logic             o_bubble,
  output logic             o_prog_reset,
  output logic             o_done,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic            halt_seen, halt_seen_nxt;
  logic [DW-1:0]   drain_cnt, drain_nxt;
  logic [CNT_W-1:0] cycle_count;
  logic            count_inc;
  logic            advance;
  logic            is_halt;
  logic            drain_last;
  logic            prog_reset_q;
  logic            done_q;

  // Freeze decoded purely from state so the latch enables have no input paths.
  assign o_stall    = !(state == S_RUN || state == S_STEP || state == S_DRAIN);
  assign o_pc_hold  = halt_seen;
  assign o_bubble   = halt_seen;
  assign advance    = !o_stall && !i_ext_stall;
  assign is_halt    = (i_if_instruction == HALT_WORD);
  assign drain_last = (drain_cnt == DW'(1));

  always_comb begin
    state_nxt     = state;
    halt_seen_nxt = halt_seen;
    drain_nxt     = drain_cnt;
    count_inc     = 1'b0;
    if (i_clear) begin
      state_nxt     = S_IDLE;
      halt_seen_nxt = 1'b0;
      drain_nxt     = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_prog_loaded && i_start)     state_nxt = S_RUN;
          else if (i_prog_loaded && i_step) state_nxt = S_STEP;
        end
        // RUN resumed after a paused drain keeps counting the drain down.
        S_RUN, S_DRAIN: begin
          if (i_halt_req) begin
            state_nxt = S_IDLE;
          end else if (advance) begin
            count_inc = 1'b1;
            if (halt_seen) begin
              drain_nxt = drain_cnt - DW'(1);
              if (drain_last) state_nxt = S_DONE;
            end else if (is_halt) begin
              halt_seen_nxt = 1'b1;
              drain_nxt     = DW'(DRAIN_CYCLES);
              state_nxt     = S_DRAIN;
            end
          end
        end
        S_STEP: begin
          if (advance) begin
            count_inc = 1'b1;
            state_nxt = S_IDLE;
            if (halt_seen) begin
              drain_nxt = drain_cnt - DW'(1);
              if (drain_last) state_nxt = S_DONE;
            end else if (is_halt) begin
              halt_seen_nxt = 1'b1;
              drain_nxt     = DW'(DRAIN_CYCLES);
            end
          end
        end
        S_DONE:  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      halt_seen    <= 1'b0;
      drain_cnt    <= '0;
      cycle_count  <= '0;
      prog_reset_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      halt_seen    <= halt_seen_nxt;
      drain_cnt    <= drain_nxt;
      prog_reset_q <= i_clear;
      done_q       <= (state_nxt == S_DONE) && (state != S_DONE);
      if (i_clear)
        cycle_count <= '0;
      else if (count_inc && (cycle_count != {CNT_W{1'b1}}))
        cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  assign o_state       = state;
  assign o_cycle_count = cycle_count;
  assign o_prog_reset  = prog_reset_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Scoreboard bench for pipeline_exec_ctrl: directed test-plan sequences plus
// random stimulus, checked against a cycle-level behavioural model.
module tb_pipeline_exec_ctrl;

  localparam int          SIZE  = 32;
  localparam int          CW    = 8;
  localparam int          DRAIN = 4;
  localparam logic [31:0] HALT  = 32'hFFFFFFFF;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, loaded, start, step, halt_req, clear, ext_stall;
  logic [31:0]   instr;
  logic          stall, pc_hold, bubble, prog_reset, done;
  logic [2:0]    state;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  pipeline_exec_ctrl #(.SIZE(SIZE), .HALT_WORD(HALT), .DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_prog_loaded(loaded), .i_start(start), .i_step(step),
    .i_halt_req(halt_req), .i_clear(clear), .i_ext_stall(ext_stall), .i_if_instruction(instr),
    .o_stall(stall), .o_pc_hold(pc_hold), .o_bubble(bubble), .o_prog_reset(prog_reset),
    .o_done(done), .o_state(state), .o_cycle_count(count)
  );

  typedef struct {
    int st;
    bit stall, hold, prst, dn;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: named run modes, remaining-drain count and a saturating tally.
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_DONE = 4;
  int m_mode = M_IDLE;
  bit m_halted = 0;
  int m_left = 0;
  int m_cnt = 0;
  bit lv = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit ld, input bit st, input bit sp, input bit hr,
                            input bit cl, input bit ex, input logic [31:0] ins);
    int   prev;
    bit   moving;
    exp_t e;
    prev   = m_mode;
    moving = (m_mode == M_RUN || m_mode == M_STEP || m_mode == M_DRAIN) && !ex;
    e.prst = 0;
    if (r || cl) begin
      m_mode = M_IDLE; m_halted = 0; m_left = 0; m_cnt = 0;
      e.prst = cl && !r;
    end else if (m_mode == M_IDLE) begin
      if (ld && st) m_mode = M_RUN;
      else if (ld && sp) m_mode = M_STEP;
    end else if ((m_mode == M_RUN || m_mode == M_DRAIN) && hr) begin
      m_mode = M_IDLE;
    end else if (moving) begin
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      if (m_halted) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = M_DONE;
        else if (m_mode == M_STEP) m_mode = M_IDLE;
      end else if (ins == HALT) begin
        m_halted = 1;
        m_left   = DRAIN;
        m_mode   = (m_mode == M_STEP) ? M_IDLE : M_DRAIN;
      end else if (m_mode == M_STEP) begin
        m_mode = M_IDLE;
      end
    end
    e.st    = m_mode;
    e.stall = (m_mode == M_IDLE || m_mode == M_DONE);
    e.hold  = m_halted;
    e.dn    = !r && (m_mode == M_DONE) && (prev != M_DONE);
    e.cnt   = m_cnt;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("state", 32'(state), 32'(e.st));
        check("stall", 32'(stall), 32'(e.stall));
        check("pc_hold", 32'(pc_hold), 32'(e.hold));
        check("bubble", 32'(bubble), 32'(e.hold));
        check("prog_reset", 32'(prog_reset), 32'(e.prst));
        check("done", 32'(done), 32'(e.dn));
        check("cycle_count", 32'(count), 32'(e.cnt));
      end
    end
  end

  task automatic drive(input bit r, input bit st, input bit sp, input bit hr, input bit cl,
                       input bit ex, input logic [31:0] ins);
    @(negedge clk);
    rst = r; loaded = lv; start = st; step = sp; halt_req = hr; clear = cl;
    ext_stall = ex; instr = ins;
    model_step(r, lv, st, sp, hr, cl, ex, ins);
  endtask

  task automatic cyc(input bit st, input bit sp, input bit hr, input bit cl, input bit ex,
                     input logic [31:0] ins);
    drive(1'b0, st, sp, hr, cl, ex, ins);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 32'h0000_0020);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : stim
    rst = 1; loaded = 0; start = 0; step = 0; halt_req = 0; clear = 0; ext_stall = 0; instr = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    settle();
    check("reset_stall", 32'(stall), 32'd1);
    check("reset_state", 32'(state), 32'd0);

    // Run to HALT on the 10th advance cycle, then drain.
    lv = 1;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 32'(i + 1));
    cyc(0, 0, 0, 0, 0, HALT);
    settle();
    check("halt_state", 32'(state), 32'd3);
    check("halt_pc_hold", 32'(pc_hold), 32'd1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, HALT);
    settle();
    check("run_count14", 32'(count), 32'd14);
    check("run_done", 32'(done), 32'd1);
    check("run_state4", 32'(state), 32'd4);
    idle(2);
    cyc(1, 1, 0, 0, 0, 0);
    settle();
    check("done_ignores_start", 32'(state), 32'd4);

    cyc(0, 0, 0, 1, 0, 0);
    settle();
    check("clear_prog_reset", 32'(prog_reset), 32'd1);
    check("clear_count", 32'(count), 32'd0);
    check("clear_pc_hold", 32'(pc_hold), 32'd0);
    idle(1);

    // Three single steps.
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0, 0, 32'h1234);
      cyc(0, 0, 0, 0, 0, 32'h1234);
    end
    settle();
    check("step_count3", 32'(count), 32'd3);
    check("step_idle", 32'(state), 32'd0);

    // External stall in RUN and in DRAIN.
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, HALT);
    cyc(0, 0, 0, 0, 0, HALT);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, HALT);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, HALT);
    settle();
    check("stall_count10", 32'(count), 32'd10);
    check("stall_done", 32'(state), 32'd4);

    // Pause mid-drain with two cycles left, then resume.
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, HALT);
    cyc(0, 0, 0, 0, 0, HALT);
    cyc(0, 0, 0, 0, 0, HALT);
    cyc(0, 0, 1, 0, 0, HALT);
    settle();
    check("pause_state", 32'(state), 32'd0);
    check("pause_stall", 32'(stall), 32'd1);
    idle(3);
    cyc(1, 0, 0, 0, 0, HALT);
    cyc(0, 0, 0, 0, 0, HALT);
    settle();
    check("resume_not_done", 32'(state), 32'd1);
    cyc(0, 0, 0, 0, 0, HALT);
    settle();
    check("resume_done", 32'(state), 32'd4);
    check("resume_count", 32'(count), 32'd5);

    // Start beats step; start without a loaded program is ignored.
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    settle();
    check("start_wins", 32'(state), 32'd1);
    cyc(0, 0, 0, 1, 0, 0);
    lv = 0;
    cyc(1, 0, 0, 0, 0, 0);
    settle();
    check("unloaded_idle", 32'(state), 32'd0);
    check("unloaded_stall", 32'(stall), 32'd1);
    lv = 1;

    // Saturation of the cycle counter.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < CMAX + 15; i++) cyc(0, 0, 0, 0, 0, 32'(i));
    settle();
    check("saturate", 32'(count), 32'(CMAX));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      lv  = ($urandom_range(0, 19) != 0);
      ins = ($urandom_range(0, 15) == 0) ? HALT : ($urandom() & 32'h7FFF_FFFF);
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 149) == 0, $urandom_range(0, 4) == 0, ins);
    end

    idle(1);
    repeat (3) settle();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
